credit_accumulator: RTL and testbench
=====================================

# credit_accumulator

Parametrised coin-credit accumulator for the vending machine datapath. It replaces the plain running-sum register with four behaviours: saturation against a maximum credit with coin rejection, price deduction through a buy handshake, change/refund hand-off through a valid/ready handshake, and an optional idle auto-refund. It sits between the coin acceptor front end and the product dispense/change controller.

## Interface
Parameters:
- AMT_W, 8: width of credit, price and refund amount.
- COIN_W, 5: width of coin_value.
- MAX_CREDIT, 200: highest credit ever held; must be ≤ 2^AMT_W−1.
- TIMEOUT_CYC, 1024: idle cycles before auto-refund; used only with IDLE_REFUND_EN.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- coin_valid  in  1  one-cycle strobe: coin_value is present.
- coin_value  in  COIN_W  denomination (1, 5, 10, …), zero-extended to AMT_W.
- coin_reject  out  1  one-cycle pulse: coin not credited; acceptor must return it.
- cancel  in  1  level or pulse: refund all credit.
- buy_req  in  1  one-cycle strobe: purchase at price.
- price  in  AMT_W  product price, sampled with buy_req.
- buy_ack  out  1  one-cycle pulse: price deducted, dispense.
- buy_nack  out  1  one-cycle pulse: insufficient credit or busy; nothing changed.
- credit  out  AMT_W  current credit (registered).
- refund_valid  out  1  refund_amount is valid.
- refund_amount  out  AMT_W  amount to return as change.
- refund_ready  in  1  change controller accepts the refund.
- busy  out  1  high in REFUND state.

## Operation
- FSM states: ACCUM and REFUND. Reset enters ACCUM.
- Reset values: credit=0, all pulse outputs=0, refund_valid=0, refund_amount=0, busy=0.
- ACCUM: events are resolved in this priority order, and only one event acts per cycle.
  - cancel:
    - credit≠0: go to REFUND.
    - credit=0: no effect.
  - buy_req:
    - price≤credit: credit←credit−price, pulse buy_ack.
      - If the remainder is ≠0, go to REFUND (change).
      - price=0 is legal: buy_ack is pulsed and the remainder is refunded.
    - price>credit: pulse buy_nack.
  - coin_valid:
    - credit+coin_value≤MAX_CREDIT: credit is updated.
    - Otherwise, or if coin_value=0: pulse coin_reject, credit unchanged.
  - A coin that coincides with a cancel or buy_req that acts is rejected (coin_reject pulsed).
- REFUND:
  - refund_valid=1 and refund_amount=credit, held stable until accepted.
  - On a cycle with refund_valid & refund_ready: credit←0, go to ACCUM.
  - All coins are rejected. buy_req gets buy_nack. cancel is ignored.
- Sum arithmetic is computed AMT_W+1 bits wide so that the comparison never wraps.

## Timing
- All outputs are registered.
- coin_reject, buy_ack and buy_nack pulse on the cycle after the triggering strobe and last exactly one cycle.
- credit reflects a coin or buy on the cycle after the strobe.
- refund_valid rises on the cycle after the cancel, or after the buy that left a remainder.
- The refund transfer completes on the edge where valid & ready.
  - refund_valid and busy fall on the following cycle.
  - credit reads 0 on that same following cycle.
- Back-to-back coins every cycle are accepted at full rate.
- rst assertion at any time, including mid-REFUND, clears state immediately. A pending refund is dropped; accounting recovery belongs to the system level.

## Configuration
- IDLE_REFUND_EN defined:
  - An idle counter counts cycles in ACCUM with credit≠0.
  - It clears on any coin_valid, buy_req or cancel, and on leaving ACCUM.
  - When the count reaches TIMEOUT_CYC−1, the FSM enters REFUND on the next cycle, exactly as for cancel.
- IDLE_REFUND_EN undefined: no counter is built, TIMEOUT_CYC is ignored, and credit is held indefinitely.

## Structure
- Shared package vm_pkg holds:
  - the state enum (ST_ACCUM, ST_REFUND);
  - default AMT_W, COIN_W and MAX_CREDIT constants;
  - coin denomination constants COIN_1, COIN_5 and COIN_10.
- One sub-module, idle_timer: a parametrised cycle counter with clear, enable and expire outputs. It is instantiated only under IDLE_REFUND_EN.

## Test plan
- Coins 10, 5, 1 on consecutive cycles → credit reads 10, 15, 16 on successive cycles, no coin_reject.
- MAX_CREDIT=20, credit=15, coin 10 → coin_reject pulse, credit stays 15. Then coin 5 → credit 20.
- credit=16, buy_req price=12 → buy_ack, refund_valid with refund_amount=4. Hold refund_ready low 3 cycles → valid stays stable. Assert refund_ready → credit 0, back to ACCUM.
- credit=6, buy_req price=12 → buy_nack, credit 6. Same cycle coin 5 + cancel → coin_reject, REFUND with refund_amount=6.
- In REFUND, coin 10 and buy_req → coin_reject and buy_nack. Assert rst mid-REFUND → credit 0, refund_valid 0 immediately.
- IDLE_REFUND_EN, TIMEOUT_CYC=8, credit=5 and no activity → refund_valid rises 8 cycles after the last event. A coin at cycle 6 restarts the count.

Source files
------------

// File: rtl/vm_pkg.sv
// vm_pkg: shared state type, default widths and coin denominations for the vending machine datapath.
// Contents: state_t (ST_ACCUM, ST_REFUND), AMT_W_DEF, COIN_W_DEF, MAX_CREDIT_DEF, COIN_1, COIN_5, COIN_10.
package vm_pkg;
    typedef enum logic {ST_ACCUM, ST_REFUND} state_t;
    localparam int AMT_W_DEF      = 8;
    localparam int COIN_W_DEF     = 5;
    localparam int MAX_CREDIT_DEF = 200;
    localparam int COIN_1         = 1;
    localparam int COIN_5         = 5;
    localparam int COIN_10        = 10;
endpackage

// File: rtl/credit_accumulator_if.sv
// credit_accumulator_if: coin, buy and refund signals between the accumulator and its neighbours.
// master drives coin_valid/coin_value/cancel/buy_req/price/refund_ready;
// slave (the accumulator) drives coin_reject/buy_ack/buy_nack/credit/refund_valid/refund_amount/busy.
interface credit_accumulator_if
    import vm_pkg::*;
#(
    parameter int AMT_W  = AMT_W_DEF,
    parameter int COIN_W = COIN_W_DEF
);
    logic              coin_valid;
    logic [COIN_W-1:0] coin_value;
    logic              coin_reject;
    logic              cancel;
    logic              buy_req;
    logic [AMT_W-1:0]  price;
    logic              buy_ack;
    logic              buy_nack;
    logic [AMT_W-1:0]  credit;
    logic              refund_valid;
    logic [AMT_W-1:0]  refund_amount;
    logic              refund_ready;
    logic              busy;

    modport master (
        output coin_valid, coin_value, cancel, buy_req, price, refund_ready,
        input  coin_reject, buy_ack, buy_nack, credit, refund_valid, refund_amount, busy
    );

    modport slave (
        input  coin_valid, coin_value, cancel, buy_req, price, refund_ready,
        output coin_reject, buy_ack, buy_nack, credit, refund_valid, refund_amount, busy
    );
endinterface

// File: rtl/idle_timer.sv
// idle_timer: counts enabled cycles since the last clear and flags expiry at TIMEOUT_CYC-1.
// Ports: clk, rst (async, active-high), clr (restart count, dominates), en (count this cycle),
// expire (en and count has reached TIMEOUT_CYC-1).
module idle_timer #(
    parameter int TIMEOUT_CYC = 1024
)(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt;

    assign expire = en && (cnt == CW'(TIMEOUT_CYC - 1));

    // Saturate at expiry so a stalled consumer never sees the count wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en && !expire) cnt <= cnt + CW'(1);
    end
endmodule

// File: rtl/credit_accumulator.sv
// credit_accumulator: saturating coin credit with price deduction and change/refund hand-off.
// Ports: clk, rst (async, active-high), bus (credit_accumulator_if.slave: coin strobe/reject,
// cancel, buy request/ack/nack, registered credit, refund valid/ready/amount, busy).
// Optional idle auto-refund is built when the macro IDLE_REFUND_EN is defined.
module credit_accumulator
    import vm_pkg::*;
#(
    parameter int AMT_W       = AMT_W_DEF,
    parameter int COIN_W      = COIN_W_DEF,
    parameter int MAX_CREDIT  = MAX_CREDIT_DEF,
    parameter int TIMEOUT_CYC = 1024
)(
    input logic                  clk,
    input logic                  rst,
    credit_accumulator_if.slave  bus
);
    if (MAX_CREDIT > (1 << AMT_W) - 1 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("credit_accumulator: MAX_CREDIT exceeds AMT_W range or TIMEOUT_CYC < 1");
    end

    state_t           state;
    logic [AMT_W-1:0] credit;
    logic [AMT_W-1:0] refund_amount;
    logic             coin_reject;
    logic             buy_ack;
    logic             buy_nack;
    logic             refund_valid;
    logic             busy;

    logic [AMT_W:0]   sum;
    logic [AMT_W-1:0] remain;
    logic             coin_ok;
    logic             cancel_act;
    logic             buy_ok;
    logic             timeout;

    // One extra bit keeps credit+coin from wrapping before the limit compare.
    assign sum        = {1'b0, credit} + (AMT_W+1)'(bus.coin_value);
    assign coin_ok    = bus.coin_valid && (bus.coin_value != '0) && (sum <= (AMT_W+1)'(MAX_CREDIT));
    assign cancel_act = bus.cancel && (credit != '0);
    assign buy_ok     = bus.buy_req && (bus.price <= credit);
    assign remain     = credit - bus.price;

`ifdef IDLE_REFUND_EN
    idle_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_idle_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (state != ST_ACCUM || bus.coin_valid || bus.buy_req || bus.cancel),
        .en     (state == ST_ACCUM && credit != '0),
        .expire (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_ACCUM;
            credit        <= '0;
            coin_reject   <= 1'b0;
            buy_ack       <= 1'b0;
            buy_nack      <= 1'b0;
            refund_valid  <= 1'b0;
            refund_amount <= '0;
            busy          <= 1'b0;
        end else begin
            coin_reject <= 1'b0;
            buy_ack     <= 1'b0;
            buy_nack    <= 1'b0;
            if (state == ST_ACCUM) begin
                if (cancel_act || timeout) begin
                    state         <= ST_REFUND;
                    refund_valid  <= 1'b1;
                    refund_amount <= credit;
                    busy          <= 1'b1;
                    coin_reject   <= bus.coin_valid;
                end else if (buy_ok) begin
                    credit        <= remain;
                    buy_ack       <= 1'b1;
                    coin_reject   <= bus.coin_valid;
                    if (remain != '0) begin
                        state         <= ST_REFUND;
                        refund_valid  <= 1'b1;
                        refund_amount <= remain;
                        busy          <= 1'b1;
                    end
                end else begin
                    // A refused buy changes nothing, so a coin in the same cycle is still judged on its own.
                    buy_nack    <= bus.buy_req;
                    coin_reject <= bus.coin_valid && !coin_ok;
                    credit      <= coin_ok ? sum[AMT_W-1:0] : credit;
                end
            end else begin
                coin_reject <= bus.coin_valid;
                buy_nack    <= bus.buy_req;
                if (refund_valid && bus.refund_ready) begin
                    state         <= ST_ACCUM;
                    credit        <= '0;
                    refund_valid  <= 1'b0;
                    refund_amount <= '0;
                    busy          <= 1'b0;
                end
            end
        end
    end

    assign bus.credit        = credit;
    assign bus.coin_reject   = coin_reject;
    assign bus.buy_ack       = buy_ack;
    assign bus.buy_nack      = buy_nack;
    assign bus.refund_valid  = refund_valid;
    assign bus.refund_amount = refund_amount;
    assign bus.busy          = busy;
endmodule

// File: tb/tb_credit_accumulator.sv
// tb_credit_accumulator: directed vectors with a pulse/refund scoreboard for credit_accumulator.
module tb_credit_accumulator;
    import vm_pkg::*;

    typedef struct {
        string name;
        logic  cr;
        logic  ack;
        logic  nack;
        int    cred;
    } pexp_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    int    checks = 0;
    int    failures = 0;
    pexp_t pq[$];
    int    rq[$];
    pexp_t mon_e;
    int    mon_r;

    credit_accumulator_if #(.AMT_W(8), .COIN_W(5)) bus ();

    credit_accumulator #(
        .AMT_W(8), .COIN_W(5), .MAX_CREDIT(20), .TIMEOUT_CYC(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic drive(input logic cv, input int cval, input logic can, input logic br, input int pr, input logic rr);
        @(posedge clk);
        #1;
        bus.coin_valid   = cv;
        bus.coin_value   = 5'(cval);
        bus.cancel       = can;
        bus.buy_req      = br;
        bus.price        = 8'(pr);
        bus.refund_ready = rr;
    endtask

    task automatic idle();
        drive(1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic coin(input int v);
        drive(1'b1, v, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic expect_pulse(input string name, input logic cr, input logic ack, input logic nack, input int cred);
        pexp_t e;
        e.name = name;
        e.cr   = cr;
        e.ack  = ack;
        e.nack = nack;
        e.cred = cred;
        pq.push_back(e);
    endtask

    // Monitor: pops an expectation whenever a pulse or a refund transfer is presented.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.coin_reject || bus.buy_ack || bus.buy_nack) begin
                if (pq.size() == 0) begin
                    chk("unexpected_pulse", {29'd0, bus.coin_reject, bus.buy_ack, bus.buy_nack}, 0);
                end else begin
                    mon_e = pq.pop_front();
                    chk({mon_e.name, "_pulses"}, {29'd0, bus.coin_reject, bus.buy_ack, bus.buy_nack},
                        {29'd0, mon_e.cr, mon_e.ack, mon_e.nack});
                    chk({mon_e.name, "_credit"}, bus.credit, mon_e.cred);
                end
            end
            if (bus.refund_valid && bus.refund_ready) begin
                if (rq.size() == 0) begin
                    chk("unexpected_refund", bus.refund_amount, -1);
                end else begin
                    mon_r = rq.pop_front();
                    chk("refund_amount_xfer", bus.refund_amount, mon_r);
                end
            end
        end
    end

    initial begin
        bus.coin_valid   = 1'b0;
        bus.coin_value   = '0;
        bus.cancel       = 1'b0;
        bus.buy_req      = 1'b0;
        bus.price        = '0;
        bus.refund_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_credit", bus.credit, 0);
        chk("rst_refund_valid", bus.refund_valid, 0);
        chk("rst_refund_amount", bus.refund_amount, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_pulses", {29'd0, bus.coin_reject, bus.buy_ack, bus.buy_nack}, 0);

        // Back-to-back coins at full rate.
        coin(COIN_10);
        coin(COIN_5);  chk("acc_10", bus.credit, 10);
        coin(COIN_1);  chk("acc_15", bus.credit, 15);
        idle();        chk("acc_16", bus.credit, 16);

        // Buy with change; refund held until ready.
        drive(1'b0, 0, 1'b0, 1'b1, 12, 1'b0);
        expect_pulse("buy12_ack", 1'b0, 1'b1, 1'b0, 4);
        idle();
        chk("chg_credit", bus.credit, 4);
        chk("chg_valid", bus.refund_valid, 1);
        chk("chg_amount", bus.refund_amount, 4);
        chk("chg_busy", bus.busy, 1);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("chg_hold_valid", bus.refund_valid, 1);
            chk("chg_hold_amount", bus.refund_amount, 4);
        end
        drive(1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
        rq.push_back(4);
        idle();
        chk("chg_done_valid", bus.refund_valid, 0);
        chk("chg_done_busy", bus.busy, 0);
        chk("chg_done_credit", bus.credit, 0);

        // Saturation at MAX_CREDIT=20.
        coin(COIN_10);
        coin(COIN_5);  chk("sat_10", bus.credit, 10);
        coin(COIN_10); chk("sat_15", bus.credit, 15);
        expect_pulse("sat_over", 1'b1, 1'b0, 1'b0, 15);
        coin(COIN_5);  chk("sat_kept", bus.credit, 15);
        coin(COIN_1);  chk("sat_20", bus.credit, 20);
        expect_pulse("sat_full", 1'b1, 1'b0, 1'b0, 20);
        coin(0);
        expect_pulse("coin_zero", 1'b1, 1'b0, 1'b0, 20);
        idle();        chk("sat_hold", bus.credit, 20);

        // Exact price: no remainder, no refund.
        drive(1'b0, 0, 1'b0, 1'b1, 20, 1'b0);
        expect_pulse("buy_exact", 1'b0, 1'b1, 1'b0, 0);
        idle();
        chk("exact_credit", bus.credit, 0);
        chk("exact_no_refund", bus.refund_valid, 0);

        // Cancel at zero credit has no effect, so the coin counts; then a zero-price buy refunds all.
        drive(1'b1, COIN_5, 1'b1, 1'b0, 0, 1'b0);
        idle();
        chk("cancel0_credit", bus.credit, 5);
        chk("cancel0_no_refund", bus.refund_valid, 0);
        drive(1'b0, 0, 1'b0, 1'b1, 0, 1'b0);
        expect_pulse("buy_zero", 1'b0, 1'b1, 1'b0, 5);
        idle();
        chk("buy0_valid", bus.refund_valid, 1);
        chk("buy0_amount", bus.refund_amount, 5);
        drive(1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
        rq.push_back(5);
        idle();        chk("buy0_done_credit", bus.credit, 0);

        // Insufficient credit, then coin coinciding with an acting cancel.
        coin(COIN_1);
        coin(COIN_5);  chk("nack_pre_1", bus.credit, 1);
        drive(1'b0, 0, 1'b0, 1'b1, 12, 1'b0);
        expect_pulse("buy_nack", 1'b0, 1'b0, 1'b1, 6);
        chk("nack_pre_6", bus.credit, 6);
        drive(1'b1, COIN_5, 1'b1, 1'b0, 0, 1'b0);
        expect_pulse("cancel_coin", 1'b1, 1'b0, 1'b0, 6);
        chk("nack_credit", bus.credit, 6);
        idle();
        chk("cancel_valid", bus.refund_valid, 1);
        chk("cancel_amount", bus.refund_amount, 6);

        // In REFUND: coins rejected, buys nacked, cancel ignored; then async reset mid-refund.
        drive(1'b1, COIN_10, 1'b0, 1'b1, 12, 1'b0);
        expect_pulse("refund_busy", 1'b1, 1'b0, 1'b1, 6);
        drive(1'b0, 0, 1'b1, 1'b0, 0, 1'b0);
        idle();
        chk("refund_cancel_valid", bus.refund_valid, 1);
        chk("refund_cancel_amount", bus.refund_amount, 6);
        chk("refund_busy_flag", bus.busy, 1);
        #3 rst = 1'b1;
        #1;
        chk("arst_credit", bus.credit, 0);
        chk("arst_valid", bus.refund_valid, 0);
        chk("arst_amount", bus.refund_amount, 0);
        chk("arst_busy", bus.busy, 0);
        #2 rst = 1'b0;

`ifdef IDLE_REFUND_EN
        // Idle auto-refund with TIMEOUT_CYC=8; a coin at cycle 6 restarts the count.
        coin(COIN_5);
        for (int i = 0; i < 5; i++) begin
            idle();
            chk("idle_early", bus.refund_valid, 0);
        end
        coin(COIN_1);
        for (int i = 0; i <= 8; i++) begin
            idle();
            chk("idle_restart", bus.refund_valid, (i == 8) ? 1 : 0);
        end
        chk("idle_amount", bus.refund_amount, 6);
        drive(1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
        rq.push_back(6);
        idle();        chk("idle_done_credit", bus.credit, 0);
`else
        // Without the idle feature credit is held indefinitely.
        coin(COIN_5);
        repeat (20) idle();
        chk("hold_no_refund", bus.refund_valid, 0);
        chk("hold_credit", bus.credit, 5);
        drive(1'b0, 0, 1'b1, 1'b0, 0, 1'b0);
        idle();
        chk("hold_cancel_amount", bus.refund_amount, 5);
        drive(1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
        rq.push_back(5);
        idle();        chk("hold_done_credit", bus.credit, 0);
`endif

        repeat (3) idle();
        chk("pulse_queue_empty", pq.size(), 0);
        chk("refund_queue_empty", rq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
